// File: rtl/wb_sdr_traffic_gen_if.sv
// Wishbone master/slave bundle between the traffic generator and the SDRAM controller port.
// Latency: none, wires only.
// Backpressure: the slave stalls a beat by holding wb_ack_i low.
// Ports: cyc/stb/we/addr/dat_o/sel/cti from master; ack/dat_i from slave.
interface wb_sdr_traffic_gen_if #(
    parameter int dw = 32,
    parameter int aw = 26
);
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [aw-1:0]   wb_addr_o;
    logic [dw-1:0]   wb_dat_o;
    logic [dw/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i;
    logic [dw-1:0]   wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/wb_sdr_traffic_gen.sv
// Wishbone burst traffic generator: writes a pattern, reads it back and counts mismatches.
// Latency: first stb the cycle after start; one beat per clock with back-to-back acks.
// Backpressure: addr/data/cti hold while ack is low; a watchdog aborts a beat stalled 2^tow-1 cycles.
// Ports: wb_clk_i/wb_rst_i (sync, active high); start + cfg_* launch a run; busy/done/timeout/
//        err_cnt/first_err_addr report status; wb carries the Wishbone master port.
module wb_sdr_traffic_gen #(
    parameter int dw  = 32,
    parameter int aw  = 26,
    parameter int bl  = 5,
    parameter int nbw = 16,
    parameter int ecw = 16,
    parameter int tow = 10
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    input  logic           start,
    input  logic [1:0]     cfg_mode,
    input  logic           cfg_pattern,
    input  logic [31:0]    cfg_seed,
    input  logic [aw-1:0]  cfg_base_addr,
    input  logic [bl-1:0]  cfg_burst_len,
    input  logic [nbw-1:0] cfg_num_bursts,
    output logic           busy,
    output logic           done,
    output logic           timeout,
    output logic [ecw-1:0] err_cnt,
    output logic [aw-1:0]  first_err_addr,
    wb_sdr_traffic_gen_if.master wb
);

    localparam int lanes = dw / 32;
    localparam int bytes = dw / 8;
    // Galois feedback mask for x^32+x^22+x^2+x+1 in right-shift form.
    localparam logic [31:0]    lfsr_taps = 32'h8020_0003;
    localparam logic [2:0]     cti_incr  = 3'b010;
    localparam logic [2:0]     cti_end   = 3'b111;
    // The stall that would take the counter to 2^tow-1 is the one that aborts.
    localparam logic [tow-1:0] wd_last   = tow'((2 ** tow) - 2);

    typedef enum logic [2:0] {
        IDLE, WR_BURST, WR_GAP, RD_BURST, RD_GAP, FIN
    } state_t;

    state_t         state;
    logic           rd_en_q;
    logic           lfsr_q;
    logic [31:0]    seed_q;
    logic [aw-1:0]  base_q;
    logic [bl-1:0]  len_q;
    logic [nbw-1:0] nb_q;
    logic [31:0]    pat;
    logic [bl-1:0]  beat;
    logic [nbw-1:0] burst;
    logic [tow-1:0] wd;
    logic           cyc, stb, we;
    logic [aw-1:0]  addr;
    logic [2:0]     cti;

    logic [bl-1:0]  len_in;
    logic [aw-1:0]  base_in;
    logic [31:0]    seed_in;

    function automatic logic [31:0] pat_step(input logic [31:0] p, input logic use_lfsr);
        if (use_lfsr)
            return p[0] ? ((p >> 1) ^ lfsr_taps) : (p >> 1);
        return p + 32'd1;
    endfunction

    function automatic logic [2:0] first_cti(input logic [bl-1:0] len);
        return (len == bl'(1)) ? cti_end : cti_incr;
    endfunction

    always_comb begin
        len_in  = (cfg_burst_len == '0) ? bl'(1) : cfg_burst_len;
        base_in = cfg_base_addr & ~aw'(bytes - 1);
        // LFSR locks up at zero, so a zero seed becomes 1 in that mode.
        seed_in = (cfg_pattern && cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
    end

    // The pattern word is held in a register, so dat_o is a registered output.
    assign wb.wb_cyc_o  = cyc;
    assign wb.wb_stb_o  = stb;
    assign wb.wb_we_o   = we;
    assign wb.wb_addr_o = addr;
    assign wb.wb_dat_o  = {lanes{pat}};
    assign wb.wb_sel_o  = '1;
    assign wb.wb_cti_o  = cti;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            rd_en_q        <= 1'b0;
            lfsr_q         <= 1'b0;
            seed_q         <= '0;
            base_q         <= '0;
            len_q          <= '0;
            nb_q           <= '0;
            pat            <= '0;
            beat           <= '0;
            burst          <= '0;
            wd             <= '0;
            cyc            <= 1'b0;
            stb            <= 1'b0;
            we             <= 1'b0;
            addr           <= '0;
            cti            <= 3'b000;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_en_q        <= cfg_mode[1];
                        lfsr_q         <= cfg_pattern;
                        seed_q         <= seed_in;
                        base_q         <= base_in;
                        len_q          <= len_in;
                        nb_q           <= cfg_num_bursts;
                        pat            <= seed_in;
                        addr           <= base_in;
                        beat           <= '0;
                        burst          <= '0;
                        wd             <= '0;
                        cti            <= first_cti(len_in);
                        busy           <= 1'b1;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        timeout        <= 1'b0;
                        if (cfg_mode[0] && cfg_num_bursts != '0) begin
                            state <= WR_BURST;
                            cyc   <= 1'b1;
                            stb   <= 1'b1;
                            we    <= 1'b1;
                        end else if (cfg_mode[1] && cfg_num_bursts != '0) begin
                            state <= RD_BURST;
                            cyc   <= 1'b1;
                            stb   <= 1'b1;
                            we    <= 1'b0;
                        end else begin
                            state <= FIN;
                        end
                    end
                end

                WR_BURST, RD_BURST: begin
                    if (wb.wb_ack_i) begin
                        wd   <= '0;
                        addr <= addr + aw'(bytes);
                        pat  <= pat_step(pat, lfsr_q);
                        if (state == RD_BURST && wb.wb_dat_i != {lanes{pat}}) begin
                            if (err_cnt == '0)
                                first_err_addr <= addr;
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + ecw'(1);
                        end
                        if (beat == len_q - bl'(1)) begin
                            cyc   <= 1'b0;
                            stb   <= 1'b0;
                            state <= (state == WR_BURST) ? WR_GAP : RD_GAP;
                        end else begin
                            beat <= beat + bl'(1);
                            // len_q >= 2 here, so len_q-2 cannot underflow.
                            if (beat == len_q - bl'(2))
                                cti <= cti_end;
                        end
                    end else if (wd == wd_last) begin
                        timeout <= 1'b1;
                        cyc     <= 1'b0;
                        stb     <= 1'b0;
                        we      <= 1'b0;
                        state   <= FIN;
                    end else begin
                        wd <= wd + tow'(1);
                    end
                end

                WR_GAP, RD_GAP: begin
                    beat <= '0;
                    wd   <= '0;
                    cti  <= first_cti(len_q);
                    if (burst != nb_q - nbw'(1)) begin
                        burst <= burst + nbw'(1);
                        cyc   <= 1'b1;
                        stb   <= 1'b1;
                        state <= (state == WR_GAP) ? WR_BURST : RD_BURST;
                    end else if (state == WR_GAP && rd_en_q) begin
                        // Read phase replays the same address range and pattern.
                        burst <= '0;
                        addr  <= base_q;
                        pat   <= seed_q;
                        cyc   <= 1'b1;
                        stb   <= 1'b1;
                        we    <= 1'b0;
                        state <= RD_BURST;
                    end else begin
                        we    <= 1'b0;
                        state <= FIN;
                    end
                end

                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    we    <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sdr_traffic_gen.sv
module tb_wb_sdr_traffic_gen;
    localparam int DW  = 32;
    localparam int AW  = 26;
    localparam int BL  = 5;
    localparam int NBW = 16;
    localparam int ECW = 16;
    localparam int TOW = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [1:0]     cfg_mode;
    logic           cfg_pattern;
    logic [31:0]    cfg_seed;
    logic [AW-1:0]  cfg_base_addr;
    logic [BL-1:0]  cfg_burst_len;
    logic [NBW-1:0] cfg_num_bursts;
    logic           busy, done, timeout;
    logic [ECW-1:0] err_cnt;
    logic [AW-1:0]  first_err_addr;

    wb_sdr_traffic_gen_if #(.dw(DW), .aw(AW)) wb ();

    wb_sdr_traffic_gen #(.dw(DW), .aw(AW), .bl(BL), .nbw(NBW), .ecw(ECW), .tow(TOW)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .start         (start),
        .cfg_mode      (cfg_mode),
        .cfg_pattern   (cfg_pattern),
        .cfg_seed      (cfg_seed),
        .cfg_base_addr (cfg_base_addr),
        .cfg_burst_len (cfg_burst_len),
        .cfg_num_bursts(cfg_num_bursts),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_err_addr(first_err_addr),
        .wb            (wb)
    );

    initial forever #5 clk = ~clk;

    // Slave: word memory indexed by address bits [11:2], optional bit0 flip on one read address.
    logic [31:0]   mem [0:1023];
    logic          ack_en = 1'b0;
    logic          cor_en = 1'b0;
    logic [AW-1:0] cor_addr = '0;
    int            ack_pct = 100;
    wire           cor_hit = cor_en && !wb.wb_we_o && (wb.wb_addr_o == cor_addr);
    assign wb.wb_ack_i = wb.wb_cyc_o & wb.wb_stb_o & ack_en;
    assign wb.wb_dat_i = mem[wb.wb_addr_o[11:2]] ^ {31'd0, cor_hit};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   dat;
        logic [2:0]    cti;
    } beat_t;

    typedef struct {
        logic [1:0]     mode;
        logic           pat;
        logic [31:0]    seed;
        logic [AW-1:0]  base;
        logic [BL-1:0]  len;
        logic [NBW-1:0] nb;
        int             ack_pct;
        logic           cor_en;
        logic [AW-1:0]  cor_addr;
        int             exp_beats;   // -1: model only
        int             exp_err;     // -1: model only
        logic [AW-1:0]  exp_first;
        logic [31:0]    exp_d0;
        logic [31:0]    exp_d1;
        int             exp_cycles;  // start edge to done cycle, -1: not checked
    } vec_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    gap_cycles, done_cnt, viol, stb_cycles;
    logic  prev_pend = 1'b0;
    beat_t prev_b;

    // One clock: new ack decision at the falling edge, then observe the bus.
    task automatic cycle();
        beat_t cur;
        @(negedge clk);
        ack_en = ($urandom_range(99) < ack_pct);
        #1;
        cur = '{we: wb.wb_we_o, addr: wb.wb_addr_o, dat: wb.wb_dat_o[31:0], cti: wb.wb_cti_o};
        if (wb.wb_stb_o !== wb.wb_cyc_o) viol++;
        if (prev_pend && wb.wb_stb_o && cur !== prev_b) viol++;
        if (wb.wb_stb_o) stb_cycles++;
        if (busy && !wb.wb_cyc_o) gap_cycles++;
        if (done) done_cnt++;
        if (wb.wb_ack_i) begin
            got_q.push_back(cur);
            if (wb.wb_we_o) mem[wb.wb_addr_o[11:2]] = wb.wb_dat_o[31:0];
        end
        prev_pend = wb.wb_stb_o && !wb.wb_ack_i;
        prev_b    = cur;
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        // Multiply by x modulo the polynomial, bit-reversed Galois representation.
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Expected beat list plus expected read-check outcome against a copy of the slave memory.
    task automatic build_model(input vec_t v, output int exp_err, output logic [AW-1:0] exp_first,
                               output int bursts);
        logic [31:0]   m [0:1023];
        logic [AW-1:0] a;
        logic [31:0]   w, word, seen;
        int            nlen, k;
        logic [31:0]   seed_eff;
        m = mem;
        exp_q.delete();
        exp_err = 0;
        exp_first = '0;
        bursts = 0;
        nlen = (v.len == 0) ? 1 : int'(v.len);
        seed_eff = (v.pat && v.seed == 0) ? 32'd1 : v.seed;
        for (int ph = 0; ph < 2; ph++) begin
            if (v.mode[ph] && v.nb != 0) begin
                a = v.base & ~AW'(3);
                w = seed_eff;
                k = 0;
                for (int b = 0; b < int'(v.nb); b++) begin
                    bursts++;
                    for (int j = 0; j < nlen; j++) begin
                        word = v.pat ? w : seed_eff + 32'(k);
                        exp_q.push_back('{we: (ph == 0), addr: a, dat: word,
                                          cti: (j == nlen - 1) ? 3'b111 : 3'b010});
                        if (ph == 0) m[a[11:2]] = word;
                        else begin
                            seen = m[a[11:2]] ^ {31'd0, (v.cor_en && a == v.cor_addr)};
                            if (seen != word) begin
                                if (exp_err == 0) exp_first = a;
                                exp_err++;
                            end
                        end
                        a = a + AW'(4);
                        w = lfsr_next(w);
                        k++;
                    end
                end
            end
        end
    endtask

    task automatic run(input string name, input vec_t v);
        int            exp_err, bursts, n;
        logic [AW-1:0] exp_first;
        build_model(v, exp_err, exp_first, bursts);
        got_q.delete();
        gap_cycles = 0; done_cnt = 0; viol = 0; stb_cycles = 0; prev_pend = 1'b0;
        ack_pct = v.ack_pct; cor_en = v.cor_en; cor_addr = v.cor_addr;
        cfg_mode = v.mode; cfg_pattern = v.pat; cfg_seed = v.seed; cfg_base_addr = v.base;
        cfg_burst_len = v.len; cfg_num_bursts = v.nb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        do begin
            cycle();
            n++;
            if (n == 1) chk({name, " first_stb"}, wb.wb_stb_o, exp_q.size() != 0);
        end while (busy && n < 4000);
        chk({name, " done_seen"}, done, 1'b1);
        if (v.exp_cycles >= 0) chk({name, " cycles"}, n, v.exp_cycles);
        cycle();
        chk({name, " done_pulses"}, done_cnt, 1);
        chk({name, " busy_idle"}, busy, 1'b0);
        chk({name, " gaps"}, gap_cycles, bursts + 1);
        chk({name, " hold_viol"}, viol, 0);
        chk({name, " timeout"}, timeout, 1'b0);
        chk({name, " beats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s beat%0d", name, i), got_q[i], exp_q[i]);
        chk({name, " err_cnt"}, err_cnt, exp_err);
        chk({name, " first_err"}, first_err_addr, exp_first);
        if (v.exp_beats >= 0) chk({name, " tbl_beats"}, got_q.size(), v.exp_beats);
        if (v.exp_beats >= 1) chk({name, " tbl_d0"}, got_q[0].dat, v.exp_d0);
        if (v.exp_beats >= 2) chk({name, " tbl_d1"}, got_q[1].dat, v.exp_d1);
        if (v.exp_err >= 0) begin
            chk({name, " tbl_err"}, err_cnt, v.exp_err);
            chk({name, " tbl_first"}, first_err_addr, v.exp_first);
        end
    endtask

    vec_t vecs [8];
    vec_t rv;
    int   n, to_at_drop;
    logic seen_drop;

    initial begin
        //         mode  pat   seed           base            len    nb    ack cor   cor_addr beats err first  d0             d1             cyc
        vecs[0] = '{2'd3, 1'b0, 32'h100,      26'h0,          5'd4, 16'd2, 100, 1'b0, 26'h0,  16,   0, 26'h0,  32'h100,      32'h101,      22};
        vecs[1] = '{2'd3, 1'b0, 32'h100,      26'h0,          5'd4, 16'd2, 100, 1'b1, 26'hC,  16,   1, 26'hC,  32'h100,      32'h101,      22};
        vecs[2] = '{2'd1, 1'b1, 32'h0,        26'h0,          5'd4, 16'd1, 100, 1'b0, 26'h0,   4,   0, 26'h0,  32'h1,        32'h80200003,  7};
        vecs[3] = '{2'd3, 1'b0, 32'h55,       26'h40,         5'd4, 16'd0, 100, 1'b0, 26'h0,   0,   0, 26'h0,  32'h0,        32'h0,         2};
        vecs[4] = '{2'd1, 1'b0, 32'h5,        26'h20,         5'd0, 16'd3, 100, 1'b0, 26'h0,   3,   0, 26'h0,  32'h5,        32'h6,         8};
        vecs[5] = '{2'd3, 1'b0, 32'h1000,     26'h3FFFFF8,    5'd4, 16'd1,  60, 1'b0, 26'h0,   8,   0, 26'h0,  32'h1000,     32'h1001,     -1};
        vecs[6] = '{2'd3, 1'b1, 32'hDEADBEEF, 26'h13,         5'd3, 16'd2,  50, 1'b1, 26'h18, 12,   1, 26'h18, 32'hDEADBEEF, 32'hEF76DF74, -1};
        vecs[7] = '{2'd2, 1'b0, 32'h0,        26'h200,        5'd2, 16'd2, 100, 1'b0, 26'h0,   4,  -1, 26'h0,  32'h0,        32'h1,         8};

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst = 1'b1; start = 1'b0; cfg_mode = '0; cfg_pattern = 1'b0; cfg_seed = '0;
        cfg_base_addr = '0; cfg_burst_len = '0; cfg_num_bursts = '0;
        repeat (3) cycle();
        chk("rst cyc", wb.wb_cyc_o, 1'b0);
        chk("rst stb_we", {wb.wb_stb_o, wb.wb_we_o}, 2'b00);
        chk("rst addr_dat_cti", {wb.wb_addr_o, wb.wb_dat_o, wb.wb_cti_o}, '0);
        chk("rst status", {busy, done, timeout}, 3'b000);
        chk("rst err", {err_cnt, first_err_addr}, '0);
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 8; i++) run($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 12; i++) begin
            rv.mode = 2'($urandom_range(3));
            rv.pat = 1'($urandom_range(1));
            rv.seed = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
            rv.base = AW'($urandom);
            rv.len = BL'($urandom_range(6));
            rv.nb = NBW'($urandom_range(3));
            rv.ack_pct = $urandom_range(30, 100);
            rv.cor_en = 1'($urandom_range(1));
            rv.cor_addr = (rv.base & ~AW'(3)) + AW'(4 * $urandom_range(7));
            rv.exp_beats = -1; rv.exp_err = -1; rv.exp_first = '0;
            rv.exp_d0 = '0; rv.exp_d1 = '0; rv.exp_cycles = -1;
            run($sformatf("rnd%0d", i), rv);
        end

        // Stalled slave: watchdog abort.
        got_q.delete();
        done_cnt = 0; stb_cycles = 0; seen_drop = 1'b0; to_at_drop = 0;
        ack_pct = 0; cor_en = 1'b0;
        cfg_mode = 2'd3; cfg_pattern = 1'b0; cfg_seed = 32'h7; cfg_base_addr = '0;
        cfg_burst_len = 5'd4; cfg_num_bursts = 16'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        do begin
            cycle();
            n++;
            if (!seen_drop && !wb.wb_cyc_o) begin
                seen_drop = 1'b1;
                to_at_drop = int'(timeout);
            end
        end while (busy && n < 1200);
        chk("to stb_cycles", stb_cycles, 1023);
        chk("to at cyc drop", to_at_drop, 1);
        chk("to done", {done, busy}, 2'b10);
        cycle();
        chk("to sticky", timeout, 1'b1);
        chk("to done_pulses", done_cnt, 1);
        chk("to no beats", got_q.size(), 0);

        run("after_to", vecs[0]);

        // Reset during the second write beat.
        ack_pct = 100;
        cfg_mode = 2'd1; cfg_pattern = 1'b0; cfg_seed = 32'h40; cfg_base_addr = 26'h100;
        cfg_burst_len = 5'd4; cfg_num_bursts = 16'd2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycle();
        cycle();
        chk("mid beat2 pending", {wb.wb_stb_o, wb.wb_addr_o}, {1'b1, 26'h104});
        rst = 1'b1;
        cycle();
        chk("mid rst cyc_stb", {wb.wb_cyc_o, wb.wb_stb_o}, 2'b00);
        chk("mid rst busy", {busy, done}, 2'b00);
        rst = 1'b0;
        cycle();
        run("after_rst", vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_sdr_traffic_gen.md
Name: wb_sdr_traffic_gen

Overview:
Synthesisable, parametrised Wishbone master that generates write/read burst traffic into sdrc_top's Wishbone slave port and self-checks read data. It succeeds the bench-driven stimulus with a configurable engine: data width, burst length, burst count, data pattern and phase mode. It sits on the sys-clock side, wired directly to sdrc_top's wb_* ports, and is usable in simulation and on FPGA bring-up.

Parameters:
dw, 32, Wishbone data width (32, 64 or 128; byte lanes = dw/8)
aw, 26, Wishbone byte-address width
bl, 5, burst-length field width (max beats = 2^bl-1)
nbw, 16, burst-count field width
ecw, 16, error-counter width
tow, 10, per-beat ack watchdog width

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous active-high reset
start  in  1  single-cycle pulse; launches a run when idle
cfg_mode  in  2  bit0 = write phase enable, bit1 = read/check phase enable
cfg_pattern  in  1  0 = incrementing (seed+beat), 1 = 32-bit LFSR replicated to dw
cfg_seed  in  32  pattern seed
cfg_base_addr  in  aw  start byte address; low log2(dw/8) bits ignored
cfg_burst_len  in  bl  beats per burst; 0 treated as 1
cfg_num_bursts  in  nbw  bursts per phase; 0 = empty phase
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
timeout  out  1  sticky; set when a beat waits 2^tow-1 cycles for ack
err_cnt  out  ecw  saturating read-mismatch count
first_err_addr  out  aw  byte address of first mismatch
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable
wb_addr_o  out  aw  byte address
wb_dat_o  out  dw  write data
wb_sel_o  out  dw/8  byte selects, always all ones
wb_cti_o  out  3  cycle type
wb_ack_i  in  1  slave acknowledge
wb_dat_i  in  dw  read data

Behaviour:
- Reset (sync, highest priority, including mid-burst): cyc/stb/we=0, addr/dat=0, cti=000, busy/done/timeout=0, err_cnt=0, first_err_addr=0, FSM=IDLE. The next edge drops cyc/stb.
- FSM: IDLE -> WR_BURST -> WR_GAP -> ... -> RD_BURST -> RD_GAP -> ... -> FIN -> IDLE.
- IDLE: start=1 captures all cfg_* inputs, clears err_cnt, first_err_addr and timeout, loads the pattern generator with cfg_seed, sets busy. Next state is WR_BURST if mode[0]=1 and num_bursts!=0. Otherwise it is RD_BURST if mode[1]=1 and num_bursts!=0. Otherwise it is FIN. start while busy is ignored.
- *_BURST: cyc=stb=1. we=1 in WR, 0 in RD. Each cycle with ack=1 completes one beat: addr += dw/8, pattern advances, beat counter increments. addr, data and cti hold stable while ack=0.
- cti=010 on every beat except the last, which uses 111. A 1-beat burst uses 111 only.
- After the last ack: cyc=stb=0 for exactly one cycle (*_GAP). The GAP state then either starts the next burst at the continuing address or ends the phase.
- WR phase end: address returns to cfg_base_addr, pattern reloads cfg_seed, then RD_BURST if mode[1], else FIN.
- Read check: on each ack in RD, compare wb_dat_i with the expected pattern word. On mismatch, err_cnt increments (saturates at all ones). On the first mismatch, first_err_addr = the current wb_addr_o.
- Pattern: incr mode word = seed + global beat index, zero-extended and replicated per 32-bit lane. LFSR mode uses x^32+x^22+x^2+x+1, Galois form, advancing one step per beat. The LFSR never reaches zero; a seed of 0 is substituted with 1.
- Watchdog: counter clears on each ack. When it reaches 2^tow-1 during BURST: set timeout, drop cyc/stb that cycle, go to FIN.
- FIN: busy=0, done=1 for one cycle, then IDLE. err_cnt, first_err_addr and timeout hold until the next start.
- Address wraps modulo 2^aw, with no error flagged.
- Throughput: back-to-back acks complete one beat per clock. The first stb is asserted the cycle after start.

Test Plan:
- Reset, then start with mode=11, pattern=0, seed=0x100, base=0x0, len=4, nb=2 against sdrc_top + IS42VM16400K -> 8 writes with dat 0x100..0x107, then 8 reads matching; cti sequence 010,010,010,111 per burst; err_cnt=0; single done pulse.
- Same run, with a bench monitor forcing wb_dat_i bit0 inverted on read beat 3 -> err_cnt=1, first_err_addr=0x0C.
- mode=01, pattern=1, seed=0 -> LFSR uses seed 1, first wb_dat_o=0x00000001, second 0x80200003; no read phase; done after 1 gap cycle.
- Slave ack held low -> timeout=1 after 1023 cycles, cyc=0 the same cycle, done pulse, busy=0.
- wb_rst_i asserted during the 2nd write beat -> cyc/stb/busy=0 on the next edge; a new start afterwards runs cleanly.
- nb=0 with mode=11 -> no cyc asserted; done pulses 2 cycles after start.
